fm_pattern_gen: RTL and testbench
=================================

FM_PATTERN_GEN -- requirements
Module: fm_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one monitoring word; MSB is the valid-marker bit.
REQ-002 SHALL have parameter NUM_CH, default 4, number of monitored channels (>=2).
REQ-003 SHALL have parameter DEPTH, default 8, number of pattern-memory entries (power of 2).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, idle cycles between bursts (>=1).
REQ-005 SHALL have one clock and synchronous active-low reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: mode  in  2  0=off, 1=single burst, 2=continuous, 3=passthrough.
REQ-007 start  in  1  single-cycle burst request, honoured only in IDLE with mode 1 or 2.
REQ-008 burst_len  in  $clog2(DEPTH)+1  entries per channel, sampled at start.
REQ-009 pat_we  in  1; pat_waddr  in  $clog2(DEPTH); pat_wdata  in  DATA_WIDTH-1: pattern-memory write port.
REQ-010 pt_data  in  NUM_CH*DATA_WIDTH  flattened passthrough words, channel 0 in LSBs; pt_vld  in  NUM_CH; pt_ready  out  NUM_CH.
REQ-011 mon_data  out  DATA_WIDTH; mon_ch  out  $clog2(NUM_CH); mon_vld  out  1; mon_ready  in  1.
REQ-012 busy  out  1  high when not IDLE; burst_cnt  out  16  completed bursts.

Function
REQ-013 FSM states SHALL be IDLE, SEND, GAP, PASS.
REQ-014 IDLE->SEND on start with mode 1/2 and 1<=burst_len; burst_len>DEPTH clamped to DEPTH; burst_len=0 -> stay IDLE.
REQ-015 IDLE->PASS when mode=3; start ignored outside IDLE.
REQ-016 SEND SHALL emit, for ch=0..NUM_CH-1, entries idx=0..L-1: mon_data={1'b1, pattern[idx]}, mon_ch=ch.
REQ-017 First SEND word SHALL appear with mon_vld=1 the cycle after start.
REQ-018 Output SHALL be a registered valid/ready slice: mon_data/mon_ch/mon_vld held stable while mon_vld=1 and mon_ready=0; advance only on mon_vld&&mon_ready.
REQ-019 With mon_ready=1 continuously SEND SHALL sustain one word per cycle, NUM_CH*L words total, no bubbles.
REQ-020 After last SEND handshake: SEND->GAP, mon_vld=0, burst_cnt+1 (wraps 0xFFFF->0).
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles; then mode=2 -> SEND with new burst (burst_len resampled); else -> IDLE.
REQ-022 PASS SHALL grant round-robin among pt_vld, starting after last granted channel (channel 0 first after reset).
REQ-023 pt_ready[i] SHALL be one-hot, combinationally high only for granted channel when output slice empty or being drained this cycle.
REQ-024 On grant mon_data=pt_data[i], mon_ch=i, mon_vld=1 next cycle; full throughput with mon_ready=1.
REQ-025 PASS->IDLE when mode!=3 and no word pending in slice; pending word completes first.
REQ-026 Pattern write SHALL take effect next cycle; a write during SEND to a not-yet-read entry SHALL be used.
REQ-027 Mode changes during SEND/GAP SHALL not abort the burst.

Reset
REQ-028 While rst=0: state=IDLE, mon_data=0, mon_ch=0, mon_vld=0, pt_ready=0, busy=0, burst_cnt=0, RR pointer=0, pattern memory all zeros.
REQ-029 rst=0 mid-burst SHALL abort immediately; first cycle after release outputs reset values; no partial resume.

Verification
REQ-030 Load pattern[i]=i+1, NUM_CH=4, burst_len=3, mode=1, start, mon_ready=1 -> 12 words {1,pattern} ch0:1,2,3 .. ch3:1,2,3, then burst_cnt=1, IDLE after 4 gap cycles.
REQ-031 Same burst, mon_ready toggled 1010... -> identical word sequence, data stable during stalls, no drops/duplicates.
REQ-032 mode=2, burst_len=2 -> 8 words, exactly 4 idle cycles, repeat; set mode=0 mid-burst -> burst completes, IDLE, burst_cnt incremented.
REQ-033 mode=3, pt_vld=4'b1111 held, mon_ready=1 -> mon_ch sequence 0,1,2,3,0..., one pt_ready per cycle.
REQ-034 burst_len=0 and burst_len=DEPTH+1 with start -> no output vs. DEPTH words per channel.
REQ-035 rst=0 at word 5 of burst -> mon_vld=0 next cycle, burst_cnt=0, busy=0.

Source files
------------

// File: rtl/fm_pattern_gen_if.sv
// Monitoring-word stream between the pattern generator and its consumer.
// The master drives data/channel/valid; the slave answers with ready.
interface fm_pattern_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    localparam int CW = $clog2(NUM_CH);

    logic [DATA_WIDTH-1:0] mon_data;
    logic [CW-1:0]         mon_ch;
    logic                  mon_vld;
    logic                  mon_ready;

    modport master (output mon_data, output mon_ch, output mon_vld, input mon_ready);
    modport slave  (input mon_data, input mon_ch, input mon_vld, output mon_ready);
endinterface

// File: rtl/fm_pattern_gen.sv
// Monitoring-word generator: replays a small pattern memory as bursts on every
// channel, or round-robin forwards live channel words, through one output slice.
module fm_pattern_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       burst_len,
    input  logic                         pat_we,
    input  logic [$clog2(DEPTH)-1:0]     pat_waddr,
    input  logic [DATA_WIDTH-2:0]        pat_wdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pt_data,
    input  logic [NUM_CH-1:0]            pt_vld,
    output logic [NUM_CH-1:0]            pt_ready,
    fm_pattern_gen_if.master             mon,
    output logic                         busy,
    output logic [15:0]                  burst_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NUM_CH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_PASS} state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-2:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] mon_data_reg;
    logic [CW-1:0]         mon_ch_reg;
    logic                  mon_vld_reg;
    logic [CW-1:0]         ch_reg;
    logic [AW-1:0]         idx_reg;
    logic [LW-1:0]         len_reg;
    logic                  done_reg;
    logic [CW-1:0]         rr_ptr_reg;
    logic [GW-1:0]         gap_cnt_reg;
    logic [15:0]           burst_cnt_reg;

    logic [DATA_WIDTH-1:0] pt_word [NUM_CH];
    logic                  slice_free;
    logic [LW-1:0]         len_clamped;
    logic                  gap_done;
    logic                  launch;
    logic                  idx_last;
    logic                  grant_valid;
    logic [CW-1:0]         grant_ch;
    logic                  pass_grant;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pt_word
        assign pt_word[gi] = pt_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Register-based pattern store: it must clear on reset and be readable in
    // the same cycle a word is loaded into the output slice.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                mem_reg[i] <= '0;
            end else if (pat_we && pat_waddr == AW'(i)) begin
                mem_reg[i] <= pat_wdata;
            end
        end
    end

    assign slice_free  = !mon_vld_reg || mon.mon_ready;
    assign len_clamped = (burst_len > LW'(DEPTH)) ? LW'(DEPTH) : burst_len;
    assign gap_done    = (gap_cnt_reg == GW'(GAP_CYCLES - 1));
    assign idx_last    = ({1'b0, idx_reg} == len_reg - LW'(1));
    assign launch      = (burst_len != '0) &&
                         ((state_reg == ST_IDLE && start && (mode == 2'd1 || mode == 2'd2)) ||
                          (state_reg == ST_GAP && gap_done && mode == 2'd2));

    // Search starts at rr_ptr_reg, which always names the channel after the last grant.
    always_comb begin
        int c;
        c           = 0;
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(rr_ptr_reg) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!grant_valid && pt_vld[CW'(c)]) begin
                grant_valid = 1'b1;
                grant_ch    = CW'(c);
            end
        end
    end

    assign pass_grant = rst && state_reg == ST_PASS && mode == 2'd3 && slice_free && grant_valid;
    assign pt_ready   = pass_grant ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            mon_data_reg  <= '0;
            mon_ch_reg    <= '0;
            mon_vld_reg   <= 1'b0;
            ch_reg        <= '0;
            idx_reg       <= '0;
            len_reg       <= '0;
            done_reg      <= 1'b0;
            rr_ptr_reg    <= '0;
            gap_cnt_reg   <= '0;
            burst_cnt_reg <= '0;
        end else if (launch) begin
            // Word 0 of channel 0 goes straight into the slice; pointers name the next word.
            state_reg    <= ST_SEND;
            mon_data_reg <= {1'b1, mem_reg[0]};
            mon_ch_reg   <= '0;
            mon_vld_reg  <= 1'b1;
            len_reg      <= len_clamped;
            done_reg     <= 1'b0;
            if (len_clamped == LW'(1)) begin
                idx_reg <= '0;
                ch_reg  <= CW'(1);
            end else begin
                idx_reg <= AW'(1);
                ch_reg  <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mode == 2'd3) begin
                        state_reg <= ST_PASS;
                    end
                end
                ST_SEND: begin
                    if (slice_free) begin
                        if (done_reg) begin
                            mon_vld_reg   <= 1'b0;
                            state_reg     <= ST_GAP;
                            gap_cnt_reg   <= '0;
                            burst_cnt_reg <= burst_cnt_reg + 16'd1;
                        end else begin
                            mon_data_reg <= {1'b1, mem_reg[idx_reg]};
                            mon_ch_reg   <= ch_reg;
                            mon_vld_reg  <= 1'b1;
                            if (idx_last) begin
                                idx_reg <= '0;
                                if (ch_reg == CW'(NUM_CH - 1)) begin
                                    done_reg <= 1'b1;
                                end else begin
                                    ch_reg <= ch_reg + CW'(1);
                                end
                            end else begin
                                idx_reg <= idx_reg + AW'(1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    if (slice_free) begin
                        if (pass_grant) begin
                            mon_data_reg <= pt_word[grant_ch];
                            mon_ch_reg   <= grant_ch;
                            mon_vld_reg  <= 1'b1;
                            rr_ptr_reg   <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
                        end else begin
                            mon_vld_reg <= 1'b0;
                            if (mode != 2'd3) begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign mon.mon_data = mon_data_reg;
    assign mon.mon_ch   = mon_ch_reg;
    assign mon.mon_vld  = mon_vld_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign burst_cnt    = burst_cnt_reg;
endmodule

// File: tb/tb_fm_pattern_gen.sv
// Directed and randomized bench for fm_pattern_gen: handshakes are captured at
// the falling edge and compared with word lists built from the burst/arbiter rules.
module tb_fm_pattern_gen;
    localparam int DW = 32, NC = 4, DEPTH = 8, GAP = 4, AW = 3, LW = 4, CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       mode = 2'd0;
    logic             start = 1'b0;
    logic [LW-1:0]    burst_len = '0;
    logic             pat_we = 1'b0;
    logic [AW-1:0]    pat_waddr = '0;
    logic [DW-2:0]    pat_wdata = '0;
    logic [NC*DW-1:0] pt_data = '0;
    logic [NC-1:0]    pt_vld = '0;
    logic [NC-1:0]    pt_ready;
    logic             busy;
    logic [15:0]      burst_cnt;

    fm_pattern_gen_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) mon_bus ();

    fm_pattern_gen #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .burst_len(burst_len),
        .pat_we(pat_we), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
        .pt_data(pt_data), .pt_vld(pt_vld), .pt_ready(pt_ready),
        .mon(mon_bus), .busy(busy), .burst_cnt(burst_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ch;
        int            cyc;
    } obs_t;

    obs_t          q[$];
    obs_t          expq[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            rdy_mode = 0;
    int            pass_prev = NC - 1;
    logic [DW-2:0] pat_m [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_q(input string tag, input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_reach"}, q.size() >= n, 1);
    endtask

    task automatic write_pat(input int idx, input logic [DW-2:0] val);
        pat_we    = 1'b1;
        pat_waddr = AW'(idx);
        pat_wdata = val;
        pat_m[idx] = val;
        tick();
        pat_we = 1'b0;
    endtask

    // Expected burst: every channel in turn, entries 0..L-1, marker bit set.
    task automatic build_burst(input int len);
        int l = (len > DEPTH) ? DEPTH : len;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < l; i++) begin
                expq.push_back('{data: {1'b1, pat_m[i]}, ch: CW'(c), cyc: 0});
            end
        end
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, q.size(), expq.size());
        for (int i = 0; i < q.size() && i < expq.size(); i++) begin
            check({tag, "_data"}, q[i].data, expq[i].data);
            check({tag, "_ch"}, q[i].ch, expq[i].ch);
        end
    endtask

    task automatic clear_q();
        q.delete();
        expq.delete();
    endtask

    task automatic check_contig(input string tag, input int first, input int last);
        for (int i = first + 1; i <= last && i < q.size(); i++) begin
            check(tag, q[i].cyc - q[i-1].cyc, 1);
        end
    endtask

    function automatic int next_ch(input int prev, input logic [NC-1:0] v);
        for (int k = 1; k <= NC; k++) begin
            if (v[(prev + k) % NC]) return (prev + k) % NC;
        end
        return -1;
    endfunction

    task automatic check_pass(input string tag, input logic [NC*DW-1:0] words, input logic [NC-1:0] v);
        int e;
        for (int i = 0; i < q.size(); i++) begin
            e = next_ch(pass_prev, v);
            check({tag, "_ch"}, q[i].ch, e);
            check({tag, "_data"}, q[i].data, words[e*DW +: DW]);
            pass_prev = e;
        end
    endtask

    initial begin
        mon_bus.mon_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       mon_bus.mon_ready = 1'b1;
                1:       mon_bus.mon_ready = ~mon_bus.mon_ready;
                2:       mon_bus.mon_ready = 1'($urandom_range(0, 1));
                default: mon_bus.mon_ready = 1'b0;
            endcase
        end
    end

    // Falling-edge monitor: captures handshakes and checks that stalled words are held.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [CW-1:0] prev_ch;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ch    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst && prev_stall) begin
                check("hold_vld", mon_bus.mon_vld, 1);
                check("hold_data", mon_bus.mon_data, prev_data);
                check("hold_ch", mon_bus.mon_ch, prev_ch);
            end
            if (rst && mode == 2'd3) begin
                check("pt_ready_onehot", $countones(pt_ready) <= 1, 1);
            end
            if (rst && mon_bus.mon_vld && mon_bus.mon_ready) begin
                q.push_back('{data: mon_bus.mon_data, ch: mon_bus.mon_ch, cyc: cyc});
            end
            prev_stall = rst && mon_bus.mon_vld && !mon_bus.mon_ready;
            prev_data  = mon_bus.mon_data;
            prev_ch    = mon_bus.mon_ch;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*DW-1:0] seg_data;
        logic [NC-1:0]    seg_vld;
        for (int i = 0; i < DEPTH; i++) pat_m[i] = '0;

        // Reset: outputs quiet even with passthrough requested.
        tick_n(3);
        mode   = 2'd3;
        pt_vld = '1;
        tick();
        check("rst_vld", mon_bus.mon_vld, 0);
        check("rst_data", mon_bus.mon_data, 0);
        check("rst_ch", mon_bus.mon_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", burst_cnt, 0);
        check("rst_pt_ready", pt_ready, 0);
        mode   = 2'd0;
        pt_vld = '0;
        rst    = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        // Single burst, pattern i+1, L=3, ready high.
        for (int i = 0; i < DEPTH; i++) write_pat(i, (DW-1)'(i + 1));
        clear_q();
        burst_len = 4'd3;
        mode      = 2'd1;
        pulse_start();
        check("first_vld", mon_bus.mon_vld, 1);
        check("first_data", mon_bus.mon_data, 32'h8000_0001);
        check("first_ch", mon_bus.mon_ch, 0);
        tick_n(12);
        check("gap_vld", mon_bus.mon_vld, 0);
        check("gap_cnt1", burst_cnt, 1);
        check("gap_busy", busy, 1);
        tick_n(3);
        check("gap_busy_last", busy, 1);
        tick();
        check("gap_to_idle", busy, 0);
        build_burst(3);
        compare_q("burst_l3");
        check_contig("burst_l3_contig", 0, 11);

        // Same burst with ready toggling.
        clear_q();
        rdy_mode = 1;
        pulse_start();
        wait_idle("toggle", 200);
        build_burst(3);
        compare_q("burst_toggle");
        check("toggle_cnt", burst_cnt, 2);

        // Random patterns, lengths and ready.
        for (int r = 0; r < 3; r++) begin
            int l;
            for (int i = 0; i < DEPTH; i++) write_pat(i, (DW-1)'($urandom()));
            l = $urandom_range(1, DEPTH);
            clear_q();
            rdy_mode  = 2;
            burst_len = LW'(l);
            pulse_start();
            wait_idle("rand", 400);
            build_burst(l);
            compare_q("burst_rand");
        end
        check("rand_cnt", burst_cnt, 5);

        // Length boundaries: zero is ignored, DEPTH+1 clamps to DEPTH.
        rdy_mode  = 0;
        clear_q();
        burst_len = 4'd0;
        pulse_start();
        tick_n(6);
        check("len0_busy", busy, 0);
        check("len0_words", q.size(), 0);
        check("len0_cnt", burst_cnt, 5);
        burst_len = 4'(DEPTH + 1);
        pulse_start();
        wait_idle("len9", 200);
        build_burst(DEPTH);
        compare_q("burst_clamp");
        check("clamp_cnt", burst_cnt, 6);

        // Write to an entry not yet read during the burst.
        clear_q();
        rdy_mode  = 1;
        burst_len = 4'd8;
        pulse_start();
        write_pat(7, (DW-1)'($urandom()));
        wait_idle("wr_send", 300);
        build_burst(8);
        compare_q("burst_wr");

        // Continuous mode with resampled length, then stop mid-burst.
        clear_q();
        rdy_mode  = 0;
        burst_len = 4'd2;
        mode      = 2'd2;
        pulse_start();
        burst_len = 4'd3;
        wait_q("cont", 10, 100);
        mode = 2'd0;
        wait_idle("cont", 100);
        build_burst(2);
        build_burst(3);
        compare_q("burst_cont");
        if (q.size() >= 20) begin
            check("cont_gap", q[8].cyc - q[7].cyc, GAP + 1);
            check_contig("cont_contig1", 0, 7);
            check_contig("cont_contig2", 8, 19);
        end
        check("cont_cnt", burst_cnt, 9);

        // Passthrough: all channels valid, full throughput.
        clear_q();
        for (int c = 0; c < NC; c++) pt_data[c*DW +: DW] = $urandom();
        pt_vld = 4'b1111;
        mode   = 2'd3;
        tick_n(14);
        pt_vld = '0;
        tick_n(4);
        check("pass_all_count", q.size() >= 12, 1);
        check_contig("pass_all_contig", 0, 11);
        check_pass("pass_all", pt_data, 4'b1111);

        for (int s = 0; s < 2; s++) begin
            clear_q();
            seg_vld  = NC'($urandom_range(1, 15));
            for (int c = 0; c < NC; c++) seg_data[c*DW +: DW] = $urandom();
            pt_data  = seg_data;
            pt_vld   = seg_vld;
            rdy_mode = 2;
            tick_n(30);
            pt_vld   = '0;
            rdy_mode = 0;
            tick_n(5);
            check("pass_rand_some", q.size() > 0, 1);
            check_pass("pass_rand", seg_data, seg_vld);
        end

        // Leaving passthrough with a stalled word: it must complete first.
        clear_q();
        rdy_mode = 3;
        pt_vld   = 4'b0100;
        tick_n(3);
        pt_vld = '0;
        mode   = 2'd0;
        tick_n(3);
        check("pass_pend_busy", busy, 1);
        check("pass_pend_vld", mon_bus.mon_vld, 1);
        check("pass_pend_ch", mon_bus.mon_ch, 2);
        rdy_mode = 0;
        tick_n(3);
        check("pass_exit_busy", busy, 0);
        check("pass_exit_vld", mon_bus.mon_vld, 0);
        check("pass_exit_words", q.size(), 1);

        // Reset while word 5 is in the slice.
        for (int i = 0; i < DEPTH; i++) write_pat(i, (DW-1)'(i + 1));
        clear_q();
        burst_len = 4'd3;
        mode      = 2'd1;
        pulse_start();
        wait_q("mid_rst", 4, 50);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) pat_m[i] = '0;
        tick();
        check("mid_rst_vld", mon_bus.mon_vld, 0);
        check("mid_rst_data", mon_bus.mon_data, 0);
        check("mid_rst_cnt", burst_cnt, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        check("rel_vld", mon_bus.mon_vld, 0);
        check("rel_busy", busy, 0);
        tick_n(3);
        check("no_resume_vld", mon_bus.mon_vld, 0);
        check("no_resume_words", q.size(), 4);

        // Pattern memory cleared by reset.
        clear_q();
        burst_len = 4'd2;
        pulse_start();
        wait_idle("zero_mem", 100);
        build_burst(2);
        compare_q("burst_zero");
        check("zero_cnt", burst_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
